// File: rtl/led_vu_meter.sv
// ---------------------------------------------------------------------------
// led_vu_meter
// Bar-graph level meter for the 8 board LEDs. Samples the equalizer's
// stereo output on each valid strobe, converts the louder channel's peak
// magnitude to a log-spaced 0..8 level with hold and decay, and overlays a
// slower peak-hold dot.
//
// Ports:
//   clk      in   1  system clock
//   rst      in   1  asynchronous reset, active-high
//   valid    in   1  one-cycle strobe, lft_out/rht_out carry a new sample
//   lft_out  in  16  signed left sample
//   rht_out  in  16  signed right sample
//   en       in   1  meter enable; low blanks the LEDs and clears all state
//   LED      out  8  active-high bar, LED[0] is the lowest level
//
// Pipeline: magnitude (stage 1) -> level/hold/decay (stage 2) -> LED (stage 3).
// A valid in cycle N is visible on LED in cycle N+3.
// ---------------------------------------------------------------------------
module led_vu_meter #(
    parameter int HOLD_SMPLS    = 4800,
    parameter int DECAY_SMPLS   = 480,
    parameter int PK_HOLD_SMPLS = 48000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [15:0] lft_out,
    input  logic [15:0] rht_out,
    input  logic        en,
    output logic [7:0]  LED
);

    // Narrowest counters that hold each parameter value.
    localparam int HW = $clog2(HOLD_SMPLS + 1);
    localparam int DW = (DECAY_SMPLS > 1) ? $clog2(DECAY_SMPLS) : 1;
    localparam int PW = $clog2(PK_HOLD_SMPLS + 1);

    localparam logic [HW-1:0] HOLD_LD  = HW'(HOLD_SMPLS);
    localparam logic [DW-1:0] DCY_LAST = DW'(DECAY_SMPLS - 1);
    localparam logic [PW-1:0] PK_LD    = PW'(PK_HOLD_SMPLS);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);
    localparam logic [DW-1:0] DCY_ONE  = DW'(1);
    localparam logic [PW-1:0] PK_ONE   = PW'(1);

    // Absolute value; -32768 has no positive counterpart and saturates.
    function automatic logic [14:0] abs_sat(input logic [15:0] s);
        logic [15:0] neg;
        neg = (~s) + 16'd1;
        if (s == 16'h8000) begin
            abs_sat = 15'h7FFF;
        end else if (s[15]) begin
            abs_sat = neg[14:0];
        end else begin
            abs_sat = s[14:0];
        end
    endfunction

    // Count of thresholds 128<<k (k = 0..7) that the magnitude reaches.
    function automatic logic [3:0] level_of(input logic [14:0] m);
        logic [3:0] n;
        n = 4'd0;
        for (int k = 0; k < 8; k++) begin
            if (m >= (15'd128 << k)) begin
                n = n + 4'd1;
            end
        end
        return n;
    endfunction

    logic [14:0]   mag_q, mag_d;
    logic          v1_q, v1_d;
    logic [3:0]    lvl_q, lvl_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [DW-1:0] dcy_cnt_q, dcy_cnt_d;
    logic [3:0]    pk_q, pk_d;
    logic [PW-1:0] pk_cnt_q, pk_cnt_d;
    logic [7:0]    led_q, led_d;

    logic [14:0]   abs_l_s, abs_r_s;
    logic [3:0]    inst_s;

    assign abs_l_s = abs_sat(lft_out);
    assign abs_r_s = abs_sat(rht_out);
    assign inst_s  = level_of(mag_q);

    // Stage 1: capture the louder channel's magnitude on valid.
    always_comb begin
        mag_d = mag_q;
        v1_d  = 1'b0;
        if (!en) begin
            mag_d = 15'd0;
            v1_d  = 1'b0;
        end else if (valid) begin
            mag_d = (abs_l_s >= abs_r_s) ? abs_l_s : abs_r_s;
            v1_d  = 1'b1;
        end else begin
            mag_d = mag_q;
            v1_d  = 1'b0;
        end
    end

    // Stage 2: bar level with hold/decay, and the peak dot that falls to
    // the bar's next-state level once its own hold expires.
    always_comb begin
        lvl_d      = lvl_q;
        hold_cnt_d = hold_cnt_q;
        dcy_cnt_d  = dcy_cnt_q;
        pk_d       = pk_q;
        pk_cnt_d   = pk_cnt_q;
        if (!en) begin
            lvl_d      = 4'd0;
            hold_cnt_d = '0;
            dcy_cnt_d  = '0;
            pk_d       = 4'd0;
            pk_cnt_d   = '0;
        end else if (v1_q) begin
            if (inst_s >= lvl_q) begin
                lvl_d      = inst_s;
                hold_cnt_d = HOLD_LD;
                dcy_cnt_d  = '0;
            end else if (hold_cnt_q != '0) begin
                hold_cnt_d = hold_cnt_q - HOLD_ONE;
            end else if (dcy_cnt_q == DCY_LAST) begin
                if (lvl_q != 4'd0) begin
                    lvl_d = lvl_q - 4'd1;
                end else begin
                    lvl_d = 4'd0;
                end
                dcy_cnt_d = '0;
            end else begin
                dcy_cnt_d = dcy_cnt_q + DCY_ONE;
            end

            if (inst_s >= pk_q) begin
                pk_d     = inst_s;
                pk_cnt_d = PK_LD;
            end else if (pk_cnt_q != '0) begin
                pk_cnt_d = pk_cnt_q - PK_ONE;
            end else begin
                pk_d = lvl_d;
            end
        end else begin
            lvl_d = lvl_q;
        end
    end

    // Stage 3: bar below lvl, plus the dot at position pk-1.
    always_comb begin
        led_d = 8'h00;
        if (en) begin
            for (int i = 0; i < 8; i++) begin
                led_d[i] = (4'(i) < lvl_q) ||
                           ((pk_q != 4'd0) && (4'(i) == (pk_q - 4'd1)));
            end
        end else begin
            led_d = 8'h00;
        end
    end

    // Pipeline and meter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_q      <= 15'd0;
            v1_q       <= 1'b0;
            lvl_q      <= 4'd0;
            hold_cnt_q <= '0;
            dcy_cnt_q  <= '0;
            pk_q       <= 4'd0;
            pk_cnt_q   <= '0;
            led_q      <= 8'h00;
        end else begin
            mag_q      <= mag_d;
            v1_q       <= v1_d;
            lvl_q      <= lvl_d;
            hold_cnt_q <= hold_cnt_d;
            dcy_cnt_q  <= dcy_cnt_d;
            pk_q       <= pk_d;
            pk_cnt_q   <= pk_cnt_d;
            led_q      <= led_d;
        end
    end

    assign LED = led_q;

endmodule

// File: tb/tb_led_vu_meter.sv
// ---------------------------------------------------------------------------
// tb_led_vu_meter
// Directed-vector bench for led_vu_meter with short hold/decay/peak
// parameters (4 / 2 / 10 samples) so the hold and decay paths are reached.
// ---------------------------------------------------------------------------
module tb_led_vu_meter;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [15:0] lft_out;
    logic [15:0] rht_out;
    logic        en;
    logic [7:0]  LED;

    int n_tests = 0;
    int n_fail  = 0;

    led_vu_meter #(
        .HOLD_SMPLS    (4),
        .DECAY_SMPLS   (2),
        .PK_HOLD_SMPLS (10)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .valid   (valid),
        .lft_out (lft_out),
        .rht_out (rht_out),
        .en      (en),
        .LED     (LED)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present one sample for one cycle; returns one edge after the strobe.
    task automatic send(input logic [15:0] l, input logic [15:0] r);
        @(negedge clk);
        valid   = 1'b1;
        lft_out = l;
        rht_out = r;
        @(negedge clk);
        valid   = 1'b0;
        lft_out = 16'd0;
        rht_out = 16'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // LED after each silent sample following one 20000 sample.
    logic [7:0] decay_exp [12] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                   8'hFF, 8'hBF, 8'hBF, 8'h9F, 8'h1F, 8'h0F};
    logic [7:0] ramp_exp  [8]  = '{8'h01, 8'h03, 8'h07, 8'h0F,
                                   8'h1F, 8'h3F, 8'h7F, 8'hFF};

    initial begin
        rst     = 1'b1;
        en      = 1'b1;
        valid   = 1'b0;
        lft_out = 16'd0;
        rht_out = 16'd0;
        tick(2);
        check_eq("reset_led", {8'h00, LED}, 16'h0000);
        rst = 1'b0;

        // Threshold and latency.
        send(16'd255, 16'd0);
        tick(1);
        check_eq("lat_before", {8'h00, LED}, 16'h0000);
        tick(1);
        check_eq("thr_255", {8'h00, LED}, 16'h0001);
        send(16'd256, 16'd0);
        tick(2);
        check_eq("thr_256", {8'h00, LED}, 16'h0003);
        send(16'h8000, 16'd0);
        tick(2);
        check_eq("thr_sat", {8'h00, LED}, 16'h00FF);

        // Asynchronous reset mid-run, seen between clock edges.
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_eq("async_rst", {8'h00, LED}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        send(16'd0, 16'd0);
        tick(2);
        check_eq("post_rst_silence", {8'h00, LED}, 16'h0000);

        // Louder channel wins.
        send(16'd1000, 16'hEC78);   // R = -5000
        check_eq("chan_mag", {1'b0, dut.mag_q}, 16'd5000);
        tick(2);
        check_eq("chan_led", {8'h00, LED}, 16'h003F);

        // Hold, decay and peak dot.
        do_reset();
        send(16'd20000, 16'd0);
        tick(2);
        check_eq("hold_start", {8'h00, LED}, 16'h00FF);
        for (int s = 0; s < 12; s++) begin
            send(16'd0, 16'd0);
            tick(2);
            check_eq($sformatf("decay_s%0d", s + 1), {8'h00, LED}, {8'h00, decay_exp[s]});
        end

        // Back-to-back valid with rising magnitudes.
        do_reset();
        for (int j = 0; j < 11; j++) begin
            @(negedge clk);
            if (j >= 3) begin
                check_eq($sformatf("b2b_%0d", j - 3), {8'h00, LED}, {8'h00, ramp_exp[j - 3]});
            end
            if (j < 8) begin
                valid   = 1'b1;
                lft_out = 16'd128 << j;
                rht_out = 16'd0;
            end else begin
                valid   = 1'b0;
                lft_out = 16'd0;
            end
        end

        // Enable low blanks and clears; samples are ignored.
        @(negedge clk);
        en = 1'b0;
        send(16'h7FFF, 16'h8000);
        tick(2);
        check_eq("en_low", {8'h00, LED}, 16'h0000);
        @(negedge clk);
        en = 1'b1;
        send(16'd300, 16'd0);
        tick(1);
        check_eq("en_lat_before", {8'h00, LED}, 16'h0000);
        tick(1);
        check_eq("en_rise_300", {8'h00, LED}, 16'h0003);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
